// File: rtl/int_ctrl.sv
// Four-source edge-latched interrupt controller: fixed priority (source 0 highest),
// per-source mask, one-cycle request with handler vector, single-level service until fin.
module int_ctrl #(
  parameter logic [9:0] VEC0 = 10'h3F0,
  parameter logic [9:0] VEC1 = 10'h3F4,
  parameter logic [9:0] VEC2 = 10'h3F8,
  parameter logic [9:0] VEC3 = 10'h3FC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       int_en,
  input  logic       mask_we,
  input  logic [3:0] mask_d,
  input  logic       fin,
  output logic       int_req,
  output logic [9:0] vector,
  output logic [1:0] active_id,
  output logic       busy,
  output logic [3:0] pending,
  output logic [3:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] prev;
  logic [3:0] edge_det;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [1:0] win_id;
  logic       take;

  assign edge_det = irq & ~prev;
  assign eligible = pending & mask;

  always_comb begin
    win_id = 2'd0;
    if (eligible[0])      win_id = 2'd0;
    else if (eligible[1]) win_id = 2'd1;
    else if (eligible[2]) win_id = 2'd2;
    else if (eligible[3]) win_id = 2'd3;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    clr       = 4'b0000;
    int_req   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (int_en && (eligible != 4'b0000)) begin
          take      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        int_req   = 1'b1;
        busy      = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: begin
        busy = 1'b1;
        if (fin) begin
          clr       = 4'b0001 << active_id;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vector = 10'h000;
    if (busy) begin
      case (active_id)
        2'd0:    vector = VEC0;
        2'd1:    vector = VEC1;
        2'd2:    vector = VEC2;
        default: vector = VEC3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new edge on the source being retired outranks its clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= 4'b0000;
      pending   <= 4'b0000;
      mask      <= 4'b1111;
      active_id <= 2'd0;
    end else begin
      prev    <= irq;
      pending <= (pending & ~clr) | edge_det;
      if (mask_we) begin
        mask <= mask_d;
      end
      if (take) begin
        active_id <= win_id;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl plus hand sequences for level/reset corners.
module tb_int_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq;
  logic       int_en;
  logic       mask_we;
  logic [3:0] mask_d;
  logic       fin;
  logic       int_req;
  logic [9:0] vector;
  logic [1:0] active_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] mask;

  int total;
  int bad;

  int_ctrl dut (
    .clk       (clk),
    .reset     (rst_n),
    .irq       (irq),
    .int_en    (int_en),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .fin       (fin),
    .int_req   (int_req),
    .vector    (vector),
    .active_id (active_id),
    .busy      (busy),
    .pending   (pending),
    .mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       en;
    logic       mwe;
    logic [3:0] md;
    logic       fin;
    logic       req;
    logic [9:0] vec;
    logic       busy;
    logic [3:0] pend;
    logic [1:0] aid;
    logic [3:0] msk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] i_irq, input logic i_en, input logic i_mwe,
                     input logic [3:0] i_md, input logic i_fin, input logic e_req,
                     input logic [9:0] e_vec, input logic e_busy, input logic [3:0] e_pend,
                     input logic [1:0] e_aid, input logic [3:0] e_msk);
    vec_t v;
    v.irq  = i_irq;
    v.en   = i_en;
    v.mwe  = i_mwe;
    v.md   = i_md;
    v.fin  = i_fin;
    v.req  = e_req;
    v.vec  = e_vec;
    v.busy = e_busy;
    v.pend = e_pend;
    v.aid  = e_aid;
    v.msk  = e_msk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nreq;
    bit fin_given;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    irq     = 4'b0000;
    int_en  = 1'b1;
    mask_we = 1'b0;
    mask_d  = 4'b0000;
    fin     = 1'b0;

    //   irq   en mwe md    fin  req vec     busy pend   aid  msk
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0000, 0, 4'hF); // 0
    add(4'h4, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0100, 0, 4'hF); // 1 single source
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F8, 1, 4'b0100, 2, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3F8, 1, 4'b0100, 2, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0000, 0, 4'hF); // 5
    add(4'hA, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b1010, 0, 4'hF); // priority 3 vs 1
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F4, 1, 4'b1010, 1, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3F4, 1, 4'b1010, 1, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b1000, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3FC, 1, 4'b1000, 3, 4'hF); // 10
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3FC, 1, 4'b1000, 3, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF);
    add(4'h0, 1, 1, 4'hE, 0,   0, 10'h000, 0, 4'b0000, 0, 4'hE); // mask source 0
    add(4'h1, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hE);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hE); // 15
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hE);
    add(4'h0, 1, 1, 4'hF, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hF); // unmask
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F0, 1, 4'b0001, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3F0, 1, 4'b0001, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF); // 20
    add(4'h1, 0, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hF); // global disable
    add(4'h0, 0, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hF);
    add(4'h0, 0, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0001, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F0, 1, 4'b0001, 0, 4'hF);
    add(4'h0, 0, 0, 4'h0, 0,   0, 10'h3F0, 1, 4'b0001, 0, 4'hF); // 25 no abort
    add(4'h0, 0, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0000, 0, 4'hF);
    add(4'h2, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0010, 0, 4'hF); // set/clear coincidence
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F4, 1, 4'b0010, 1, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3F4, 1, 4'b0010, 1, 4'hF); // 30
    add(4'h2, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0010, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   1, 10'h3F4, 1, 4'b0010, 1, 4'hF);
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h3F4, 1, 4'b0010, 1, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF);
    add(4'h0, 1, 0, 4'h0, 1,   0, 10'h000, 0, 4'b0000, 0, 4'hF); // 35 fin in IDLE
    add(4'h0, 1, 0, 4'h0, 0,   0, 10'h000, 0, 4'b0000, 0, 4'hF);

    #12;
    chk("rst_req", {31'd0, int_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vec", {22'd0, vector}, 32'h000);
    chk("rst_aid", {30'd0, active_id}, 32'd0);
    chk("rst_pend", {28'd0, pending}, 32'h0);
    chk("rst_mask", {28'd0, mask}, 32'hF);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      irq     = tbl[i].irq;
      int_en  = tbl[i].en;
      mask_we = tbl[i].mwe;
      mask_d  = tbl[i].md;
      fin     = tbl[i].fin;
      step();
      chk($sformatf("v%0d_req", i), {31'd0, int_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d_vec", i), {22'd0, vector}, {22'd0, tbl[i].vec});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_pend", i), {28'd0, pending}, {28'd0, tbl[i].pend});
      chk($sformatf("v%0d_mask", i), {28'd0, mask}, {28'd0, tbl[i].msk});
      if (tbl[i].busy) begin
        chk($sformatf("v%0d_aid", i), {30'd0, active_id}, {30'd0, tbl[i].aid});
      end
    end
    irq = 4'h0; int_en = 1'b1; mask_we = 1'b0; fin = 1'b0;

    // Level held high across reset release: one edge, one request.
    rst_n = 1'b0;
    irq   = 4'b0001;
    #2;
    chk("lvl_pend_in_rst", {28'd0, pending}, 32'h0);
    step();
    chk("lvl_busy_in_rst", {31'd0, busy}, 32'd0);
    rst_n     = 1'b1;
    nreq      = 0;
    fin_given = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (int_req) nreq++;
      if (busy && !int_req && !fin_given) begin
        fin       = 1'b1;
        fin_given = 1'b1;
      end else begin
        fin = 1'b0;
      end
    end
    fin = 1'b0;
    chk("lvl_req_count", nreq, 32'd1);
    chk("lvl_pend_end", {28'd0, pending}, 32'h0);
    chk("lvl_busy_end", {31'd0, busy}, 32'd0);
    irq = 4'b0000;
    step();

    // Async reset while in SERVICE; masking the active source first must not abort.
    irq = 4'b1000;
    step();
    irq = 4'b0000;
    step();
    chk("ar_req", {31'd0, int_req}, 32'd1);
    chk("ar_vec_req", {22'd0, vector}, 32'h3FC);
    mask_we = 1'b1;
    mask_d  = 4'b0111;
    step();
    mask_we = 1'b0;
    chk("ar_busy_svc", {31'd0, busy}, 32'd1);
    chk("ar_mask_wr", {28'd0, mask}, 32'h7);
    chk("ar_vec_svc", {22'd0, vector}, 32'h3FC);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req_rst", {31'd0, int_req}, 32'd0);
    chk("ar_busy_rst", {31'd0, busy}, 32'd0);
    chk("ar_pend_rst", {28'd0, pending}, 32'h0);
    chk("ar_mask_rst", {28'd0, mask}, 32'hF);
    chk("ar_vec_rst", {22'd0, vector}, 32'h000);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("ar_idle_after", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
